// File: rtl/czono_pkg.sv
// Shared types and helpers for the constrained-zonotope stream reader:
// section encoding, header packing and the section-skip sequencing rule.
package czono_pkg;

  typedef enum logic [2:0] {IDLE, HDR, C, G, A, B, DRAIN} czono_sec_e;

  localparam logic [7:0] HDR_MAGIC = 8'hC2;

  function automatic logic [31:0] pack_header(input logic [7:0] n, input logic [7:0] ng,
                                              input logic [7:0] nc);
    return {HDR_MAGIC, nc, ng, n};
  endfunction

  // Next non-empty section after s; empty sections are skipped, DRAIN once nothing is left.
  function automatic czono_sec_e next_sec(input czono_sec_e s, input logic [7:0] n,
                                          input logic [7:0] ng, input logic [7:0] nc);
    czono_sec_e r;
    r = DRAIN;
    if (s == HDR && n != 8'd0)
      r = C;
    else if ((s == HDR || s == C) && n != 8'd0 && ng != 8'd0)
      r = G;
    else if ((s == HDR || s == C || s == G) && ng != 8'd0 && nc != 8'd0)
      r = A;
    else if ((s == HDR || s == C || s == G || s == A) && nc != 8'd0)
      r = B;
    return r;
  endfunction

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry FIFO holding {last, data} words between the RAM read path and the stream port.
module stream_fifo2 #(
  parameter int W = 33
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem_reg [2];
  logic         wr_ptr_reg;
  logic         rd_ptr_reg;
  logic [1:0]   count_reg;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mem_reg[0] <= '0;
      mem_reg[1] <= '0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) begin
        mem_reg[wr_ptr_reg] <= din;
        wr_ptr_reg          <= ~wr_ptr_reg;
      end
      if (pop)
        rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  assign dout  = mem_reg[rd_ptr_reg];
  assign full  = count_reg == 2'd2;
  assign empty = count_reg == 2'd0;
  assign count = count_reg;

endmodule

// File: rtl/czonotope_stream_reader.sv
// Serializes a constrained zonotope (header, c, G, A, b) from its block RAMs onto a
// valid/ready word stream, keeping at most two words in flight ahead of the consumer.
module czonotope_stream_reader
  import czono_pkg::*;
#(
  parameter int NMAX       = 3,
  parameter int NGMAX      = 15,
  parameter int NCMAX      = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        start_i,
  input  logic [$clog2(NMAX+1)-1:0]   n_i,
  input  logic [$clog2(NGMAX+1)-1:0]  ng_i,
  input  logic [$clog2(NCMAX+1)-1:0]  nc_i,
  output logic [$clog2(NMAX)-1:0]     c_addr,
  input  logic [DATA_WIDTH-1:0]       c_rdata,
  output logic [$clog2(NMAX)-1:0]     G_raddr,
  output logic [$clog2(NGMAX)-1:0]    G_caddr,
  input  logic [DATA_WIDTH-1:0]       G_rdata,
  output logic [$clog2(NCMAX)-1:0]    A_raddr,
  output logic [$clog2(NGMAX)-1:0]    A_caddr,
  input  logic [DATA_WIDTH-1:0]       A_rdata,
  output logic [$clog2(NCMAX)-1:0]    b_addr,
  input  logic [DATA_WIDTH-1:0]       b_rdata,
  output logic [DATA_WIDTH-1:0]       m_tdata,
  output logic                        m_tvalid,
  input  logic                        m_tready,
  output logic                        m_tlast,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int AW_N = $clog2(NMAX);
  localparam int AW_G = $clog2(NGMAX);
  localparam int AW_C = $clog2(NCMAX);

  czono_sec_e state_reg, tag_reg, cur_sec, nsec;
  logic [7:0] n_reg, ng_reg, nc_reg, row_reg, col_reg;
  logic [7:0] n_in, ng_in, nc_in, dn, dng, dnc, cur_row, cur_col, row_lim;
  logic       inflight_reg, tag_last_reg, busy_reg, done_reg;
  logic       idle, launch, issue, row_end, col_end, sec_end, is_last, hdr_last;
  logic       push, pop, full, empty;
  logic [1:0] fifo_count;
  logic [2:0] occ;
  logic [DATA_WIDTH-1:0] sec_data, hdr_word;
  logic [DATA_WIDTH:0]   fifo_din, fifo_dout;

  assign n_in  = 8'(n_i);
  assign ng_in = 8'(ng_i);
  assign nc_in = 8'(nc_i);

  // The start cycle already issues element 0 of the first section so the header
  // and the first RAM word leave back to back.
  always_comb begin
    idle     = state_reg == IDLE;
    launch   = idle && start_i;
    dn       = idle ? n_in  : n_reg;
    dng      = idle ? ng_in : ng_reg;
    dnc      = idle ? nc_in : nc_reg;
    cur_sec  = idle ? next_sec(HDR, n_in, ng_in, nc_in) : state_reg;
    cur_row  = idle ? 8'd0 : row_reg;
    cur_col  = idle ? 8'd0 : col_reg;
    row_lim  = (cur_sec == C || cur_sec == G) ? dn - 8'd1 : dnc - 8'd1;
    row_end  = cur_row == row_lim;
    col_end  = (cur_sec == C || cur_sec == B) ? 1'b1 : (cur_col == dng - 8'd1);
    sec_end  = row_end && col_end;
    nsec     = next_sec(cur_sec, dn, dng, dnc);
    is_last  = sec_end && nsec == DRAIN;
    hdr_last = next_sec(HDR, n_in, ng_in, nc_in) == DRAIN;
    pop      = m_tvalid && m_tready;
    push     = inflight_reg || launch;
    // Occupancy after this cycle's push/pop; a new read only goes out if its word will fit.
    occ      = 3'(fifo_count) + 3'(inflight_reg) + 3'(launch) - 3'(pop);
    issue    = (cur_sec inside {C, G, A, B}) && (launch || !idle) && occ < 3'd2;
  end

  always_comb begin
    c_addr  = '0;
    G_raddr = '0;
    G_caddr = '0;
    A_raddr = '0;
    A_caddr = '0;
    b_addr  = '0;
    if (issue) begin
      case (cur_sec)
        C: c_addr = cur_row[AW_N-1:0];
        G: begin
          G_raddr = cur_row[AW_N-1:0];
          G_caddr = cur_col[AW_G-1:0];
        end
        A: begin
          A_raddr = cur_row[AW_C-1:0];
          A_caddr = cur_col[AW_G-1:0];
        end
        B: b_addr = cur_row[AW_C-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    sec_data = '0;
    case (tag_reg)
      C:       sec_data = c_rdata;
      G:       sec_data = G_rdata;
      A:       sec_data = A_rdata;
      B:       sec_data = b_rdata;
      default: ;
    endcase
  end

  assign hdr_word = DATA_WIDTH'(pack_header(n_in, ng_in, nc_in));
  assign fifo_din = inflight_reg ? {tag_last_reg, sec_data} : {hdr_last, hdr_word};

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg    <= IDLE;
      tag_reg      <= IDLE;
      n_reg        <= 8'd0;
      ng_reg       <= 8'd0;
      nc_reg       <= 8'd0;
      row_reg      <= 8'd0;
      col_reg      <= 8'd0;
      inflight_reg <= 1'b0;
      tag_last_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg     <= 1'b0;
      inflight_reg <= issue;
      if (issue) begin
        tag_reg      <= cur_sec;
        tag_last_reg <= is_last;
      end
      if (launch) begin
        n_reg    <= n_in;
        ng_reg   <= ng_in;
        nc_reg   <= nc_in;
        busy_reg <= 1'b1;
      end
      if (issue) begin
        if (sec_end) begin
          state_reg <= nsec;
          row_reg   <= 8'd0;
          col_reg   <= 8'd0;
        end else if (row_end) begin
          state_reg <= cur_sec;
          row_reg   <= 8'd0;
          col_reg   <= cur_col + 8'd1;
        end else begin
          state_reg <= cur_sec;
          row_reg   <= cur_row + 8'd1;
          col_reg   <= cur_col;
        end
      end else if (launch) begin
        state_reg <= cur_sec;
        row_reg   <= 8'd0;
        col_reg   <= 8'd0;
      end
      if (state_reg == DRAIN && pop && fifo_dout[DATA_WIDTH]) begin
        state_reg <= IDLE;
        busy_reg  <= 1'b0;
        done_reg  <= 1'b1;
      end
    end
  end

  stream_fifo2 #(.W(DATA_WIDTH + 1)) u_fifo (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .push   (push),
    .pop    (pop),
    .din    (fifo_din),
    .dout   (fifo_dout),
    .full   (full),
    .empty  (empty),
    .count  (fifo_count)
  );

  assign m_tvalid = !empty;
  assign m_tdata  = fifo_dout[DATA_WIDTH-1:0];
  assign m_tlast  = m_tvalid && fifo_dout[DATA_WIDTH];
  assign busy_o   = busy_reg;
  assign done_o   = done_reg;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (launch)
      assert (n_in <= 8'(NMAX) && ng_in <= 8'(NGMAX) && nc_in <= 8'(NCMAX));
    if (push && !pop)
      assert (!full);
  end
`endif

endmodule

// File: tb/tb_czonotope_stream_reader.sv
// Self-checking bench: RAM models with 1-cycle reads, a sequence-level reference of the
// expected word stream, and scenario tasks covering stalls, skips, restart and reset.
module tb_czonotope_stream_reader;
  localparam int NMAX = 3, NGMAX = 15, NCMAX = 12, DW = 32;

  logic clk = 1'b0, rstn = 1'b0, start = 1'b0;
  logic [1:0] n_in = '0;
  logic [3:0] ng_in = '0, nc_in = '0;
  logic [1:0] c_addr, g_raddr;
  logic [3:0] g_caddr, a_raddr, a_caddr, b_addr;
  logic [DW-1:0] c_rdata = '0, g_rdata = '0, a_rdata = '0, b_rdata = '0, m_tdata;
  logic m_tvalid, m_tready = 1'b0, m_tlast, busy, done;

  logic [DW-1:0] c_mem [4];
  logic [DW-1:0] g_mem [4][16];
  logic [DW-1:0] a_mem [16][16];
  logic [DW-1:0] b_mem [16];
  logic [DW:0] exp_q[$], obs_q[$];
  int checks = 0, errors = 0, ready_mode = 0, done_cnt = 0, stall_viol = 0, stray_addr = 0;
  logic prev_stall = 1'b0, tog = 1'b0;
  logic [DW:0] prev_word = '0;

  always #5 clk = ~clk;

  czonotope_stream_reader #(.NMAX(NMAX), .NGMAX(NGMAX), .NCMAX(NCMAX), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .n_i(n_in), .ng_i(ng_in), .nc_i(nc_in),
    .c_addr(c_addr), .c_rdata(c_rdata), .G_raddr(g_raddr), .G_caddr(g_caddr), .G_rdata(g_rdata),
    .A_raddr(a_raddr), .A_caddr(a_caddr), .A_rdata(a_rdata), .b_addr(b_addr), .b_rdata(b_rdata),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .busy_o(busy), .done_o(done)
  );

  always @(posedge clk) begin
    c_rdata <= c_mem[c_addr];
    g_rdata <= g_mem[g_raddr][g_caddr];
    a_rdata <= a_mem[a_raddr][a_caddr];
    b_rdata <= b_mem[b_addr];
  end

  always @(posedge clk) begin
    #1;
    tog = ~tog;
    case (ready_mode)
      0: m_tready = 1'b1;
      1: m_tready = tog;
      default: m_tready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (!rstn) prev_stall = 1'b0;
    else begin
      if (prev_stall && (!m_tvalid || {m_tlast, m_tdata} !== prev_word)) stall_viol++;
      prev_stall = m_tvalid && !m_tready;
      prev_word  = {m_tlast, m_tdata};
      if (m_tvalid && m_tready) obs_q.push_back({m_tlast, m_tdata});
    end
    if (done) done_cnt++;
    if (g_raddr != '0 || g_caddr != '0 || a_raddr != '0 || a_caddr != '0 || b_addr != '0) stray_addr++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t required < 1000000", $time);
    $fatal(1);
  end

  // Expected stream straight from the format rules: header, c, G col-major, A col-major, b.
  function automatic void build_expected(input int n, input int ng, input int nc);
    logic [DW:0] w;
    exp_q.delete();
    exp_q.push_back({1'b0, 8'hC2, 8'(nc), 8'(ng), 8'(n)});
    for (int i = 0; i < n; i++) exp_q.push_back({1'b0, c_mem[i]});
    for (int k = 0; k < ng; k++) for (int r = 0; r < n; r++) exp_q.push_back({1'b0, g_mem[r][k]});
    for (int k = 0; k < ng; k++) for (int r = 0; r < nc; r++) exp_q.push_back({1'b0, a_mem[r][k]});
    for (int i = 0; i < nc; i++) exp_q.push_back({1'b0, b_mem[i]});
    w = exp_q.pop_back();
    w[DW] = 1'b1;
    exp_q.push_back(w);
  endfunction

  task automatic fill_linear();
    for (int r = 0; r < 16; r++) begin
      if (r < 4) c_mem[r] = 32'(r);
      b_mem[r] = 32'(32'h300 + r);
      for (int k = 0; k < 16; k++) begin
        if (r < 4) g_mem[r][k] = 32'(32'h100 + k * NMAX + r);
        a_mem[r][k] = 32'(32'h200 + k * NCMAX + r);
      end
    end
  endtask

  task automatic fill_random();
    for (int r = 0; r < 16; r++) begin
      if (r < 4) c_mem[r] = $urandom();
      b_mem[r] = $urandom();
      for (int k = 0; k < 16; k++) begin
        if (r < 4) g_mem[r][k] = $urandom();
        a_mem[r][k] = $urandom();
      end
    end
  endtask

  task automatic clear_obs();
    obs_q.delete();
    done_cnt = 0;
    stall_viol = 0;
    stray_addr = 0;
  endtask

  task automatic kick(input int n, input int ng, input int nc);
    @(posedge clk); #1;
    n_in = 2'(n); ng_in = 4'(ng); nc_in = 4'(nc); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cycles, output logic first_valid, output logic busy_at_done,
                           output logic seen);
    cycles = 0; seen = 1'b0; first_valid = 1'b0; busy_at_done = 1'b1;
    while (!seen && cycles < 3000) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) first_valid = m_tvalid;
      if (done) begin seen = 1'b1; busy_at_done = busy; end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({m_tvalid, m_tlast, busy, done} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl got valid/last/busy/done=%b required 0000", {m_tvalid, m_tlast, busy, done});
    end
    checks++;
    if (m_tdata !== '0 || c_addr !== '0 || stray_addr !== 0) begin
      errors++; $display("FAIL reset_data got tdata=%h c_addr=%0d required 0", m_tdata, c_addr);
    end
    @(posedge clk); #1 rstn = 1'b1;
  endtask

  task automatic test_basic();
    int cyc; logic fv, bd, seen;
    fill_linear(); clear_obs(); ready_mode = 0;
    kick(3, 2, 1); wait_done(cyc, fv, bd, seen); build_expected(3, 2, 1);
    checks++; if (!seen) begin errors++; $display("FAIL basic_done got none required pulse"); end
    checks++; if (fv !== 1'b1) begin errors++; $display("FAIL basic_first_valid got %b required 1", fv); end
    checks++; if (cyc != 14) begin errors++; $display("FAIL basic_latency got %0d required 14", cyc); end
    checks++; if (bd !== 1'b0 || done_cnt != 1) begin
      errors++; $display("FAIL basic_done_pulse got busy=%b pulses=%0d required 0/1", bd, done_cnt); end
    checks++; if (obs_q.size() < 1 || obs_q[0] !== {1'b0, 32'hC2010203}) begin
      errors++; $display("FAIL basic_header got %h required 0C2010203", obs_q.size() > 0 ? obs_q[0] : '0); end
    checks++; if (obs_q.size() != 13) begin errors++; $display("FAIL basic_count got %0d required 13", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL basic_beat%0d got %h required %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    int cyc; logic fv, bd, seen;
    fill_random();
    for (int m = 1; m <= 2; m++) begin
      clear_obs(); ready_mode = m;
      kick(3, 2, 1); wait_done(cyc, fv, bd, seen); build_expected(3, 2, 1);
      checks++; if (!seen || obs_q.size() != exp_q.size()) begin
        errors++; $display("FAIL stall%0d_count got %0d required %0d", m, obs_q.size(), exp_q.size()); end
      checks++; if (stall_viol != 0) begin errors++; $display("FAIL stall%0d_hold got %0d changes required 0", m, stall_viol); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        checks++; if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL stall%0d_beat%0d got %h required %h", m, i, obs_q[i], exp_q[i]); end
      end
    end
    ready_mode = 0;
  endtask

  task automatic test_c_only();
    int cyc; logic fv, bd, seen;
    clear_obs();
    kick(2, 0, 0); wait_done(cyc, fv, bd, seen); build_expected(2, 0, 0);
    checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL conly_count got %0d required 3", obs_q.size()); end
    checks++; if (obs_q.size() < 1 || obs_q[0] !== {1'b0, 32'hC2000002}) begin
      errors++; $display("FAIL conly_header got %h required 0C2000002", obs_q.size() > 0 ? obs_q[0] : '0); end
    checks++; if (stray_addr != 0) begin errors++; $display("FAIL conly_addr got %0d nonzero cycles required 0", stray_addr); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL conly_beat%0d got %h required %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_header_only();
    int cyc; logic fv, bd, seen;
    clear_obs();
    kick(0, 0, 0); wait_done(cyc, fv, bd, seen);
    checks++; if (obs_q.size() != 1 || obs_q[0] !== {1'b1, 32'hC2000000}) begin
      errors++; $display("FAIL hdronly_beat got n=%0d w=%h required 1 x 1C2000000", obs_q.size(), obs_q.size() > 0 ? obs_q[0] : '0); end
    checks++; if (!seen || cyc != 2 || done_cnt != 1) begin
      errors++; $display("FAIL hdronly_done got cyc=%0d pulses=%0d required 2/1", cyc, done_cnt); end
  endtask

  task automatic test_restart_and_reset();
    int cyc; logic fv, bd, seen;
    fill_random(); clear_obs(); ready_mode = 1;
    kick(3, 2, 1);
    repeat (4) @(posedge clk);
    #1 n_in = 2'd1; ng_in = 4'd1; nc_in = 4'd1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(cyc, fv, bd, seen); build_expected(3, 2, 1);
    checks++; if (!seen || obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL restart_count got %0d required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL restart_beat%0d got %h required %h", i, obs_q[i], exp_q[i]); end
    end
    clear_obs(); ready_mode = 0;
    kick(3, 2, 1);
    for (int i = 0; i < 100 && obs_q.size() < 5; i++) @(negedge clk);
    checks++; if (obs_q.size() < 5) begin errors++; $display("FAIL rst_reach got %0d beats required 5", obs_q.size()); end
    @(posedge clk); #1 rstn = 1'b0;
    #1;
    checks++; if (m_tvalid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid got valid=%b busy=%b required 0/0", m_tvalid, busy); end
    @(posedge clk); #1 rstn = 1'b1;
    clear_obs();
    kick(3, 2, 1); wait_done(cyc, fv, bd, seen);
    checks++; if (!seen || obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rst_fresh_count got %0d required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rst_fresh_beat%0d got %h required %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int cyc; logic fv, bd, seen;
    fill_random(); clear_obs(); ready_mode = 0;
    kick(3, 15, 12); wait_done(cyc, fv, bd, seen); build_expected(3, 15, 12);
    checks++; if (obs_q.size() != 241) begin errors++; $display("FAIL full_count got %0d required 241", obs_q.size()); end
    checks++; if (!seen || cyc != 242) begin errors++; $display("FAIL full_latency got %0d required 242", cyc); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL full_beat%0d got %h required %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random_dims();
    int cyc, n, ng, nc; logic fv, bd, seen;
    for (int t = 0; t < 4; t++) begin
      fill_random(); clear_obs(); ready_mode = 2;
      n = int'($urandom_range(0, NMAX)); ng = int'($urandom_range(0, NGMAX)); nc = int'($urandom_range(0, NCMAX));
      kick(n, ng, nc); wait_done(cyc, fv, bd, seen); build_expected(n, ng, nc);
      checks++; if (!seen || obs_q.size() != 1 + n + n * ng + nc * ng + nc) begin
        errors++; $display("FAIL rand%0d_count dims %0d/%0d/%0d got %0d required %0d", t, n, ng, nc,
                           obs_q.size(), 1 + n + n * ng + nc * ng + nc); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        checks++; if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rand%0d_beat%0d got %h required %h", t, i, obs_q[i], exp_q[i]); end
      end
    end
    ready_mode = 0;
  endtask

  initial begin
    fill_linear();
    test_reset();
    test_basic();
    test_backpressure();
    test_c_only();
    test_header_only();
    test_restart_and_reset();
    test_back_to_back();
    test_random_dims();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
